vga_frame_controller: RTL and testbench
=======================================

# vga_frame_controller

- Sink end of the pixel path: consumes the registered `Red_level`/`Green_level`/`Blue_level` stream from the object mux and drives the VGA DAC pins.
- Source end of the same path: generates the raster `pixelX`/`pixelY` coordinates that every drawer and the mux are evaluated against.
- Delays sync and blank through a matched pipeline so colour and sync stay aligned despite the drawer and mux register stages.

## Interface

Parameters:

- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch
- `PIPE_DELAY`, 2: cycles from `pixelX`/`pixelY` to the matching `*_level` input; legal range 1..4

Ports:

- `clk`  in  1  pixel clock, 25 MHz; the only clock
- `resetN`  in  1  synchronous, active-low reset
- `Red_level`, `Green_level`, `Blue_level`  in  4 each  colour from the object mux
- `pixelX`  out  11  horizontal counter, 0..H_TOTAL-1
- `pixelY`  out  11  vertical counter, 0..V_TOTAL-1
- `startOfFrame`  out  1  high for the single cycle where pixelX==0 and pixelY==0
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each  DAC colour
- `VGA_HS`, `VGA_VS`  out  1 each  syncs, active-low
- `VGA_BLANK_N`  out  1  high during visible pixels

## Operation

- `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP (800). `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- `pixelX` increments every cycle and wraps from H_TOTAL-1 to 0.
- `pixelY` increments only on the cycle `pixelX` wraps. It wraps from V_TOTAL-1 to 0 on that same cycle.
- `pixelX`/`pixelY` also run through blanking; drawers must not draw outside the active region.
- Raw sync and blank are decoded from the current counters:
  - `hs_raw` = 0 when H_ACTIVE+H_FP ≤ pixelX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vs_raw` = 0 when V_ACTIVE+V_FP ≤ pixelY < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `active_raw` = pixelX<H_ACTIVE && pixelY<V_ACTIVE.
- `hs_raw`, `vs_raw` and `active_raw` enter a PIPE_DELAY-deep delay line.
- Output register, updated every cycle:
  - `VGA_R/G/B` ← delayed active ? `*_level` : 0
  - `VGA_HS` ← delayed hs
  - `VGA_VS` ← delayed vs
  - `VGA_BLANK_N` ← delayed active
- `startOfFrame` is a decode of the counter registers. It is forced 0 while resetN=0.

## Timing

- Reset (resetN=0 at a clk edge):
  - counters ← 0
  - every delay-line stage ← HS=1, VS=1, active=0
  - `VGA_R/G/B`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0
- First cycle after release: pixelX=0, pixelY=0, startOfFrame=1.
- Reset mid-frame: counters restart at (0,0) on the next edge. Outputs stay blank/inactive until the delay line refills (PIPE_DELAY+1 cycles). No partial sync pulse is stretched.
- Latency:
  - Coordinate presented in cycle t → its colour is sampled at the end of cycle t+PIPE_DELAY.
  - That colour appears on `VGA_*` in cycle t+PIPE_DELAY+1.
  - HS, VS and BLANK_N for that coordinate appear in the same cycle, so all pins are aligned.
- Line = 800 cycles. Frame = 420 000 cycles. HS low for exactly 96 cycles per line. VS low for exactly 2 lines (1600 cycles).
- Double wrap (pixelX=799, pixelY=524): next cycle is (0,0) with startOfFrame=1.
- `*_level` inputs are ignored, and the pins driven 0, whenever the delayed active bit is 0.

## Structure

- `vga_timing_pkg`: default timing constants, plus derived `H_TOTAL`, `V_TOTAL`, `HS_START`, `HS_END`, `VS_START`, `VS_END` and coordinate width `COORD_W`=11.
- Sub-module `sync_delay_line`:
  - parameterised width and depth shift register with synchronous active-low reset to a parameter value.
  - one instance of width 3 carries {hs, vs, active}.
- Top module holds the two counters, the decode logic and the output register.

## Test plan

- Reset release, then run 801 cycles → pixelX wraps 799→0 and pixelY becomes 1. startOfFrame is high only in cycle 0.
- PIPE_DELAY=2, one full line → `VGA_HS` low for cycles 659..754 after release (656+3), exactly 96 cycles.
- `*_level` driven as {pixelX[3:0] delayed 2, 4'h5, 4'hA} → `VGA_R` equals the low bits of the pixel index three cycles earlier across the whole active line. R/G/B read 0 at pixelX≥640 (delayed).
- Constant `*_level`=4'hF during blanking lines 480..524 → `VGA_R/G/B`=0 and `VGA_BLANK_N`=0 throughout.
- resetN pulsed low for 1 cycle at (pixelX=300, pixelY=200) → next cycle is (0,0) with startOfFrame=1. Pins are blank with HS/VS=1 for 3 cycles, then normal.
- Run 2 full frames → startOfFrame pulses exactly twice, 420 000 cycles apart. `VGA_VS` low for 1600 cycles per frame, starting 3 cycles after pixelY reaches 490 at pixelX=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_timing_pkg : default 640x480@60 raster timing and shared types     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package vga_timing_pkg;

    localparam int c_COORD_W  = 11;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;
    localparam int c_HS_START = c_H_ACTIVE + c_H_FP;
    localparam int c_HS_END   = c_HS_START + c_H_SYNC;
    localparam int c_VS_START = c_V_ACTIVE + c_V_FP;
    localparam int c_VS_END   = c_VS_START + c_V_SYNC;

    typedef logic [c_COORD_W-1:0] coord_t;

    // Field order fixes the bit layout carried by the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_bits_t;

    localparam sync_bits_t c_SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_controller_sync_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_delay_line : WIDTH x DEPTH shift register, sync active-low reset  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sync_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_tap [DEPTH+1];

    assign w_tap[0] = d;

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (!resetN) begin
                r_q <= RESET_VALUE;
            end else begin
                r_q <= w_tap[k];
            end
        end

        assign w_tap[k+1] = r_q;
    end

    assign q = w_tap[DEPTH];

endmodule
`default_nettype wire

// File: rtl/vga_frame_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_frame_controller : raster counters, sync decode, aligned DAC regs  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module vga_frame_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int H_FP       = c_H_FP,
    parameter int H_SYNC     = c_H_SYNC,
    parameter int H_BP       = c_H_BP,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int V_FP       = c_V_FP,
    parameter int V_SYNC     = c_V_SYNC,
    parameter int V_BP       = c_V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [3:0]           Red_level,
    input  logic [3:0]           Green_level,
    input  logic [3:0]           Blue_level,
    output logic [c_COORD_W-1:0] pixelX,
    output logic [c_COORD_W-1:0] pixelY,
    output logic                 startOfFrame,
    output logic [3:0]           VGA_R,
    output logic [3:0]           VGA_G,
    output logic [3:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N
);

    localparam coord_t c_X_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t c_Y_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t c_X_ACTIVE = coord_t'(H_ACTIVE);
    localparam coord_t c_Y_ACTIVE = coord_t'(V_ACTIVE);
    localparam coord_t c_HS_LO    = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_HS_HI    = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_VS_LO    = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_VS_HI    = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t     r_x;
    coord_t     r_y;
    sync_bits_t w_raw;
    sync_bits_t w_dly;
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == c_X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == c_Y_LAST) ? '0 : r_y + coord_t'(1);
        end else begin
            r_x <= r_x + coord_t'(1);
        end
    end

    always_comb begin
        w_raw        = c_SYNC_IDLE;
        w_raw.hs     = !in_span(r_x, c_HS_LO, c_HS_HI);
        w_raw.vs     = !in_span(r_y, c_VS_LO, c_VS_HI);
        w_raw.active = (r_x < c_X_ACTIVE) && (r_y < c_Y_ACTIVE);
    end

    // Delays the decode to line up with the colour arriving from the mux.
    sync_delay_line #(
        .WIDTH       (3),
        .DEPTH       (PIPE_DELAY),
        .RESET_VALUE (c_SYNC_IDLE)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .d      (w_raw),
        .q      (w_dly)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_red     <= 4'h0;
            r_green   <= 4'h0;
            r_blue    <= 4'h0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_red     <= w_dly.active ? Red_level   : 4'h0;
            r_green   <= w_dly.active ? Green_level : 4'h0;
            r_blue    <= w_dly.active ? Blue_level  : 4'h0;
            r_hs      <= w_dly.hs;
            r_vs      <= w_dly.vs;
            r_blank_n <= w_dly.active;
        end
    end

    assign pixelX       = r_x;
    assign pixelY       = r_y;
    assign startOfFrame = resetN && (r_x == '0) && (r_y == '0);
    assign VGA_R        = r_red;
    assign VGA_G        = r_green;
    assign VGA_B        = r_blue;
    assign VGA_HS       = r_hs;
    assign VGA_VS       = r_vs;
    assign VGA_BLANK_N  = r_blank_n;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vga_frame_controller : scoreboard bench on a reduced raster         |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_vga_frame_controller;

    // Reduced raster keeps multi-frame runs short: 32 x 13 = 416 cycles/frame.
    localparam int HA = 20, HF = 3, HSW = 5, HB = 4;
    localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [3:0]  red = 4'h0, green = 4'h0, blue = 4'h0;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;

    always #5 clk = ~clk;

    vga_frame_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .PIPE_DELAY(PD)
    ) dut (
        .clk(clk), .resetN(resetN),
        .Red_level(red), .Green_level(green), .Blue_level(blue),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
    );

    typedef struct {
        int          seg;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic [11:0] rgb;
        logic [2:0]  syn;   // {hs, vs, blank_n}
    } exp_t;

    exp_t        sb[$];
    logic [11:0] lvl_hist [0:4095];
    int          n = 0;
    int          seg = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (seg %0d n %0d)", name, act, req, seg, n);
        end
    endtask

    // Expected pins for cycle k counted from reset release; colour is the level
    // driven one cycle earlier, sync/blank belong to coordinate k-PD-1.
    function automatic exp_t model(int k, bit in_reset);
        exp_t e;
        int   m, xm, ym;
        bit   act;
        e.seg = seg;
        e.x   = 11'(k % HT);
        e.y   = 11'((k / HT) % VT);
        e.sof = !in_reset && (k % FRAME == 0);
        if (k >= PD + 1) begin
            m   = k - PD - 1;
            xm  = m % HT;
            ym  = (m / HT) % VT;
            act = (xm < HA) && (ym < VA);
            e.syn = {!(xm >= HA + HF && xm < HA + HF + HSW),
                     !(ym >= VA + VF && ym < VA + VF + VSW), act};
            e.rgb = act ? lvl_hist[k-1] : 12'h000;
        end else begin
            e.syn = 3'b110;
            e.rgb = 12'h000;
        end
        return e;
    endfunction

    task automatic drive_level(int k, int mode);
        case (mode)
            0:       {red, green, blue} = {((k >= 2) ? 4'((k - 2) % HT) : 4'h0), 4'h5, 4'hA};
            1:       {red, green, blue} = 12'hFFF;
            default: {red, green, blue} = 12'($urandom);
        endcase
        lvl_hist[k] = {red, green, blue};
    endtask

    task automatic run(int cycles, int mode);
        repeat (cycles) begin
            @(posedge clk); #1;
            resetN = 1'b1;
            drive_level(n, mode);
            sb.push_back(model(n, 1'b0));
            n++;
        end
    endtask

    // Monitor: one popped expectation per cycle, plus run-length bookkeeping.
    int cyc = 0;
    int sof_count = 0, last_sof_seg = -1, last_sof_cyc = 0;
    int hs_run = 0, vs_run = 0, hs_runs = 0, vs_runs = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("coord", {10'd0, pixelX, pixelY}, {10'd0, e.x, e.y});
            check("sof", 32'(startOfFrame), 32'(e.sof));
            check("rgb", {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, e.rgb});
            check("sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, {29'd0, e.syn});
            if (startOfFrame) begin
                sof_count++;
                if (last_sof_seg == e.seg) check("sof_gap", 32'(cyc - last_sof_cyc), 32'(FRAME));
                last_sof_seg = e.seg;
                last_sof_cyc = cyc;
            end
            if (!VGA_HS) hs_run++;
            else if (hs_run > 0) begin
                check("hs_width", 32'(hs_run), 32'(HSW));
                hs_runs++;
                hs_run = 0;
            end
            if (!VGA_VS) vs_run++;
            else if (vs_run > 0) begin
                check("vs_width", 32'(vs_run), 32'(VSW * HT));
                vs_runs++;
                vs_run = 0;
            end
        end
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_coord", {10'd0, pixelX, pixelY}, 32'd0);
        check("rst_sof", 32'(startOfFrame), 32'd0);
        check("rst_pins", {17'd0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'b110);

        run(FRAME, 0);           // colour = delayed pixel index pattern
        run(FRAME, 1);           // constant full-scale, must vanish in blanking
        run(3 * HT + 10, 2);     // random colour up to coordinate (10,3)

        // One-cycle reset pulse mid-frame; that cycle still shows normal pins.
        @(posedge clk); #1;
        resetN = 1'b0;
        drive_level(n, 2);
        sb.push_back(model(n, 1'b1));
        n   = 0;
        seg = 1;
        run(FRAME + 40, 2);

        @(negedge clk); #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("sof_count", 32'(sof_count), 32'd5);
        check("hs_runs", 32'(hs_runs), 32'd43);
        check("vs_runs", 32'(vs_runs), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
